// File: rtl/imem_loader_pkg.sv
// Shared types and sizing helpers for the instruction-memory loader.
package imem_loader_pkg;

  localparam int unsigned IMEM_BITSIZE = 32;
  localparam int unsigned IMEM_REGSIZE = 32;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    FINISH,
    CHECK,
    DONE
  } state_e;

  function automatic int unsigned byte_cnt_w(input int unsigned bytes);
    return (bytes > 1) ? $clog2(bytes) : 1;
  endfunction

  localparam int unsigned BYTES_PER_WORD = IMEM_BITSIZE / 8;
  localparam int unsigned BYTE_CNT_W     = byte_cnt_w(BYTES_PER_WORD);

endpackage

// File: rtl/imem_loader_word_packer.sv
// Byte-to-word assembler: little-endian shift-in, registered word with a
// one-cycle word_valid pulse the cycle after the last byte is accepted.
module imem_word_packer
  import imem_loader_pkg::*;
#(
  parameter int unsigned BYTES = BYTES_PER_WORD
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  input  logic                 last_i,
  output logic                 word_valid_o,
  output logic [8*BYTES-1:0]   word_o
);

  localparam int unsigned W = 8 * BYTES;

  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] word_q;
  logic         valid_q;

  // New bytes enter at the top so byte 0 ends up in bits [7:0].
  always_comb begin
    acc_d = (acc_q >> 8) | (W'(byte_i) << (W - 8));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      acc_q   <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= byte_valid_i & last_i;
      if (byte_valid_i) begin
        acc_q <= acc_d;
        if (last_i) begin
          word_q <= acc_d;
        end
      end
    end
  end

  assign word_valid_o = valid_q;
  assign word_o       = word_q;

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into the instruction memory write port and holds the CPU
// meanwhile. Optional trailing XOR checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned BITSIZE = IMEM_BITSIZE,
  parameter int unsigned REGSIZE = IMEM_REGSIZE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [REGSIZE-1:0] num_words,
  input  logic               in_valid,
  input  logic [7:0]         in_byte,
  output logic               in_ready,
  output logic               mem_we,
  output logic [REGSIZE-1:0] mem_addr,
  output logic [BITSIZE-1:0] mem_wdata,
  output logic               cpu_hold,
  output logic               busy,
  output logic               done,
  output logic               error
);

  localparam int unsigned BPW = BITSIZE / 8;
  localparam int unsigned BCW = byte_cnt_w(BPW);
  localparam logic [REGSIZE-1:0] DEPTH = REGSIZE'(REGSIZE);

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_e POST_DATA = CHECK;
`else
  localparam state_e POST_DATA = DONE;
`endif

  state_e             state_q, state_d;
  logic [BCW-1:0]     byte_cnt_q, byte_cnt_d;
  logic [REGSIZE-1:0] word_idx_q, word_idx_d;
  logic [REGSIZE-1:0] nwords_q, nwords_d;
  logic [REGSIZE-1:0] mem_addr_q, mem_addr_d;
  logic               error_q, error_d;
  logic               byte_fire;
  logic               last_byte;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]         csum_q, csum_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      word_idx_q <= '0;
      nwords_q   <= '0;
      mem_addr_q <= '0;
      error_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      word_idx_q <= word_idx_d;
      nwords_q   <= nwords_d;
      mem_addr_q <= mem_addr_d;
      error_q    <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum_q     <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    word_idx_d = word_idx_q;
    nwords_d   = nwords_q;
    mem_addr_d = mem_addr_q;
    error_d    = error_q;
    in_ready   = 1'b0;
    byte_fire  = 1'b0;
    last_byte  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    csum_d     = csum_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          nwords_d   = num_words;
          byte_cnt_d = '0;
          word_idx_d = '0;
          error_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d     = '0;
`endif
          if (num_words > DEPTH) begin
            error_d = 1'b1;
            state_d = DONE;
          end else if (num_words == '0) begin
            state_d = POST_DATA;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        if (in_valid) begin
          byte_fire = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          csum_d    = csum_q ^ in_byte;
`endif
          if (byte_cnt_q == BCW'(BPW - 1)) begin
            last_byte  = 1'b1;
            byte_cnt_d = '0;
            mem_addr_d = word_idx_q;
            word_idx_d = word_idx_q + REGSIZE'(1);
            if (word_idx_q == nwords_q - REGSIZE'(1)) begin
              state_d = FINISH;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + BCW'(1);
          end
        end
      end
      FINISH: begin
        state_d = POST_DATA;
      end
      CHECK: begin
`ifdef IMEM_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        if (in_valid) begin
          error_d = (in_byte != csum_q);
          state_d = DONE;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  imem_word_packer #(
    .BYTES (BPW)
  ) u_packer (
    .clk_i        (clk),
    .rst_i        (rst),
    .byte_valid_i (byte_fire),
    .byte_i       (in_byte),
    .last_i       (last_byte),
    .word_valid_o (mem_we),
    .word_o       (mem_wdata)
  );

  assign mem_addr = mem_addr_q;
  assign busy     = (state_q == LOAD) || (state_q == FINISH) || (state_q == CHECK);
  assign cpu_hold = busy;
  assign done     = (state_q == DONE);
  assign error    = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes are queued as bytes are
// driven and checked by a monitor whenever mem_we fires.
module tb_imem_loader;

  localparam int unsigned BITSIZE = 32;
  localparam int unsigned REGSIZE = 32;

  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic [REGSIZE-1:0] num_words;
  logic               in_valid;
  logic [7:0]         in_byte;
  logic               in_ready;
  logic               mem_we;
  logic [REGSIZE-1:0] mem_addr;
  logic [BITSIZE-1:0] mem_wdata;
  logic               cpu_hold;
  logic               busy;
  logic               done;
  logic               error;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         sb[$];
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  csum;

  imem_loader #(
    .BITSIZE (BITSIZE),
    .REGSIZE (REGSIZE)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write addr=%0d data=%h required=no write", mem_addr, mem_wdata);
      end else begin
        wr_t e;
        e = sb.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          n_fail++;
          $display("FAIL write addr=%0d data=%h required addr=%0d data=%h",
                   mem_addr, mem_wdata, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [REGSIZE-1:0] n);
    num_words = n;
    start     = 1'b1;
    csum      = 8'h00;
    tick();
    start     = 1'b0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    logic        rdy;
    int unsigned t;
    t        = 0;
    in_valid = 1'b1;
    in_byte  = b;
    forever begin
      rdy = in_ready;
      tick();
      if (rdy === 1'b1) break;
      t++;
      if (t > 50) begin
        n_cmp++;
        n_fail++;
        $display("FAIL byte_accept timeout byte=%h required in_ready within 50 cycles", b);
        break;
      end
    end
    csum     = csum ^ b;
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] addr, input logic [31:0] data);
    logic [31:0] d;
    d = data;
    sb.push_back('{addr, data});
    for (int k = 0; k < 4; k++) push_byte(d[8*k +: 8]);
  endtask

  task automatic end_session();
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] c;
    c = csum;
    push_byte(c);
`endif
  endtask

  task automatic wait_done();
    int unsigned t;
    t = 0;
    while (done !== 1'b1 && t < 20) begin
      tick();
      t++;
    end
    n_cmp++;
    if (done !== 1'b1) begin
      n_fail++;
      $display("FAIL done_timeout done=%b required 1", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_words = '0; in_valid = 1'b0; in_byte = '0;
    tick(); tick();
    n_cmp++;
    if ({in_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL reset_values rdy/we/hold/busy/done/err=%b addr=%h data=%h required all 0",
               {in_ready, mem_we, cpu_hold, busy, done, error}, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_stream();
    logic [7:0] b [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    sb.push_back('{32'd0, 32'h0000_0013});
    sb.push_back('{32'd1, 32'h0010_0093});
    do_start(2);
    n_cmp++;
    if ({busy, cpu_hold, in_ready} !== 3'b111) begin
      n_fail++;
      $display("FAIL stream_start busy/hold/ready=%b required 111", {busy, cpu_hold, in_ready});
    end
    for (int i = 0; i < 8; i++) begin
      push_byte(b[i]);
      if (i == 3 || i == 7) begin
        n_cmp++;
        if (mem_we !== 1'b1) begin
          n_fail++;
          $display("FAIL stream_write_latency byte=%0d mem_we=%b required 1", i, mem_we);
        end
      end
    end
`ifndef IMEM_LOADER_CHECKSUM_EN
    n_cmp++;
    if (done !== 1'b0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_finish done=%b in_ready=%b required 0 0", done, in_ready);
    end
    tick();
`else
    end_session();
    wait_done();
`endif
    n_cmp++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || in_ready !== 1'b0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_done done/hold/ready/err=%b required 1000",
               {done, cpu_hold, in_ready, error});
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL stream_writes pending=%0d required 0", sb.size());
    end
  endtask

  task automatic test_toggle();
    logic [7:0] b [8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    int unsigned ready_drops;
    ready_drops = 0;
    sb.push_back('{32'd0, 32'h0000_0013});
    sb.push_back('{32'd1, 32'h0010_0093});
    do_start(2);
    for (int i = 0; i < 8; i++) begin
      push_byte(b[i]);
      if (i < 7) begin
        if (in_ready !== 1'b1) ready_drops++;
        tick();
      end
    end
    end_session();
    wait_done();
    n_cmp++;
    if (ready_drops != 0) begin
      n_fail++;
      $display("FAIL toggle_ready drops=%0d required 0", ready_drops);
    end
    n_cmp++;
    if (sb.size() != 0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL toggle_writes pending=%0d error=%b required 0 0", sb.size(), error);
    end
  endtask

  task automatic test_oversize_and_empty();
    do_start(33);
    tick();
    n_cmp++;
    if (done !== 1'b1 || error !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL oversize done/err/busy=%b required 110", {done, error, busy});
    end
    repeat (3) tick();
    do_start(0);
    end_session();
    wait_done();
    n_cmp++;
    if (error !== 1'b0 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL zero_words error=%b pending=%0d required 0 0", error, sb.size());
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] b [6] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00};
    sb.push_back('{32'd0, 32'h0000_0013});
    do_start(2);
    for (int i = 0; i < 6; i++) push_byte(b[i]);
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({in_ready, mem_we, cpu_hold, busy, done, error} !== 6'b0 ||
        mem_addr !== '0 || mem_wdata !== '0) begin
      n_fail++;
      $display("FAIL rst_midload rdy/we/hold/busy/done/err=%b addr=%h data=%h required all 0",
               {in_ready, mem_we, cpu_hold, busy, done, error}, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    repeat (4) tick();
    send_word_session_after_reset();
  endtask

  task automatic send_word_session_after_reset();
    do_start(1);
    send_word(32'd0, 32'hDEAD_BEEF);
    end_session();
    wait_done();
    n_cmp++;
    if (sb.size() != 0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_new_session pending=%0d error=%b required 0 0", sb.size(), error);
    end
  endtask

  task automatic test_start_ignored();
    do_start(2);
    sb.push_back('{32'd0, 32'h0403_0201});
    sb.push_back('{32'd1, 32'h0807_0605});
    push_byte(8'h01);
    push_byte(8'h02);
    num_words = 1;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_midload busy=%b done=%b required 1 0", busy, done);
    end
    for (int i = 3; i <= 8; i++) push_byte(8'(i));
    end_session();
    wait_done();
    n_cmp++;
    if (sb.size() != 0 || error !== 1'b0) begin
      n_fail++;
      $display("FAIL start_ignored pending=%0d error=%b required 0 0", sb.size(), error);
    end
  endtask

  task automatic test_full_depth();
    logic [7:0] w8;
    do_start(REGSIZE);
    for (int w = 0; w < int'(REGSIZE); w++) begin
      w8 = 8'(w);
      send_word(32'(w), {w8, ~w8, 8'hC3, w8 ^ 8'h5A});
    end
    end_session();
    wait_done();
    n_cmp++;
    if (sb.size() != 0 || error !== 1'b0 || mem_addr !== 32'(REGSIZE - 1)) begin
      n_fail++;
      $display("FAIL full_depth pending=%0d error=%b last_addr=%0d required 0 0 %0d",
               sb.size(), error, mem_addr, REGSIZE - 1);
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] cs [2] = '{8'h43, 8'h44};
    logic       ex [2] = '{1'b0, 1'b1};
    for (int r = 0; r < 2; r++) begin
      do_start(1);
      send_word(32'd0, 32'h0000_7033);
      push_byte(cs[r]);
      wait_done();
      n_cmp++;
      if (error !== ex[r] || sb.size() != 0) begin
        n_fail++;
        $display("FAIL checksum csum=%h error=%b pending=%0d required error=%b pending=0",
                 cs[r], error, sb.size(), ex[r]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_toggle();
    test_oversize_and_empty();
    test_reset_midload();
    test_start_ignored();
    test_full_depth();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Write-side companion to the instruction memory: receives a byte stream over a valid/ready handshake and writes it into the instruction memory's write port. Assembles little-endian instruction words at consecutive word addresses from 0. Holds the CPU while programming, then reports completion. It sits between the host/debug byte source and the memory, ahead of instruction fetch.

## Interface
- BITSIZE, 32, instruction width in bits; multiple of 8
- REGSIZE, 32, memory depth in words; also the width of count/address ports
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a load session; sampled only in IDLE or DONE
- num_words  in  REGSIZE  words to load; latched on accepted start
- in_valid  in  1  byte source has data
- in_byte  in  8  data byte
- in_ready  out  1  loader accepts a byte this cycle
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  REGSIZE  word index being written
- mem_wdata  out  BITSIZE  assembled instruction word
- cpu_hold  out  1  high while a session is in progress
- busy  out  1  high in LOAD/FINISH/CHECK
- done  out  1  level, high in DONE
- error  out  1  session failed; valid while done=1

## Operation
- States: IDLE, LOAD, FINISH, CHECK (macro only), DONE.
- IDLE/DONE + start: latch num_words, clear byte/word counters, error <= 0.
  - num_words > REGSIZE: error <= 1, go to DONE; no writes.
  - num_words == 0: go to CHECK (macro) or DONE; no writes.
  - else go to LOAD.
- start in LOAD/FINISH/CHECK is ignored.
- LOAD: in_ready = 1. Byte k of a word (k = 0..BITSIZE/8-1) goes to bits [8k+7:8k].
- The last byte of a word is accepted at edge E. In the following cycle, mem_we = 1, mem_addr = word index, and mem_wdata = full word. The word index then increments.
- After the last byte of the last word, go to FINISH. FINISH lasts one cycle, with in_ready = 0 and the final mem_we high. Then go to CHECK (macro) or DONE.
- DONE: done = 1, cpu_hold = 0, in_ready = 0. Holds until the next start or rst.
- No address wrap: the index never exceeds num_words-1 ≤ REGSIZE-1.
- rst at any time: return to IDLE. Any partial word is discarded; no further mem_we.

## Timing
- Reset values:
  - in_ready, mem_we, cpu_hold, busy, done, error = 0
  - mem_addr, mem_wdata = 0
  - state = IDLE
- start accepted at edge S: busy, cpu_hold and in_ready are high from cycle S+1.
- Full throughput: one byte per cycle. Back-to-back words give a mem_we every BITSIZE/8 cycles.
- Write latency: one cycle after the final byte of a word is accepted.
- done rises one cycle after the final mem_we (without macro).
- in_valid without in_ready: the byte is not consumed; the source must hold it.
- mem_we is never asserted in IDLE, CHECK or DONE.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - After the last data byte, the loader spends one CHECK state with in_ready = 1 to accept one checksum byte.
  - The checksum is the XOR of all data bytes; 0x00 when num_words = 0.
  - Mismatch: error = 1. The memory keeps the written data. Then go to DONE.
- Not defined: no CHECK state; FINISH goes directly to DONE; error is set only on oversize num_words.

## Structure
- Shared package holds:
  - state enum (IDLE, LOAD, FINISH, CHECK, DONE)
  - BYTES_PER_WORD = BITSIZE/8
  - byte-counter width constant
- One sub-module: imem_word_packer. It is a byte-to-word shift/assemble register with a word_valid pulse. The FSM, counters and checksum stay in imem_loader.

## Test plan
- num_words=2; bytes 13 00 00 00 93 00 10 00 streamed continuously:
  - mem_we at addr 0 with 0x00000013, then at addr 1 with 0x00100093
  - done high one cycle after the second write; cpu_hold low in DONE
- Same stream with in_valid toggling every other cycle: same writes and data. in_ready never drops in LOAD; no bytes lost or duplicated.
- num_words=33 (REGSIZE=32): done=1 and error=1 two cycles after start; no mem_we.
- rst asserted after 6 of 8 bytes: addr 0 written; no addr 1 write. All outputs return to reset values the cycle after rst. A new session then starts at addr 0.
- start pulsed mid-LOAD: ignored. Counters and num_words are unchanged.
- With IMEM_LOADER_CHECKSUM_EN, num_words=1, bytes 33 70 00 00:
  - checksum 0x43 gives error=0
  - checksum 0x44 gives error=1
  - addr 0 holds 0x00007033 in both cases
